// File: rtl/decoder_nxm_seq.sv
// Registered N-to-2^N one-hot decoder with per-slot hold time, valid/ready
// request handshake and a scan mode that walks a contiguous output range.
module decoder_nxm_seq #(
  parameter int unsigned IN_W       = 3,
  parameter int unsigned HOLD_W     = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [IN_W-1:0]        in_sel,
  input  logic [IN_W-1:0]        scan_first,
  input  logic [IN_W-1:0]        scan_last,
  input  logic [HOLD_W-1:0]      in_hold,
  input  logic                   abort,
  output logic [(1<<IN_W)-1:0]   out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned OUT_W = 1 << IN_W;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e              r_state, w_state_nxt;
  logic [IN_W-1:0]     r_idx, w_idx_nxt;
  logic [IN_W-1:0]     r_last, w_last_nxt;
  logic [HOLD_W-1:0]   r_cnt, w_cnt_nxt;
  logic [HOLD_W-1:0]   r_reload, w_reload_nxt;
  logic [OUT_W-1:0]    r_line, w_line_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;

  logic [HOLD_W-1:0]   w_in_reload;
  logic [IN_W-1:0]     w_start_idx;
  logic [IN_W-1:0]     w_step_idx;
  logic [OUT_W-1:0]    w_one;

  // Hold of 0 behaves as 1; the counter holds cycles-remaining-minus-one.
  assign w_in_reload = (in_hold == '0) ? '0 : in_hold - HOLD_W'(1);
  assign w_start_idx = in_mode ? scan_first : in_sel;
  assign w_step_idx  = r_idx + IN_W'(1);
  assign w_one       = {{(OUT_W-1){1'b0}}, 1'b1};

  // Next-state: accept in IDLE, count down slots in HOLD, advance or finish.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;
    w_reload_nxt = r_reload;
    w_line_nxt   = r_line;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (in_valid) begin
          if (in_mode && (scan_first > scan_last)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt  = StHold;
            w_idx_nxt    = w_start_idx;
            // DIRECT is a one-slot scan ending at its own index.
            w_last_nxt   = in_mode ? scan_last : in_sel;
            w_cnt_nxt    = w_in_reload;
            w_reload_nxt = w_in_reload;
            w_line_nxt   = w_one << w_start_idx;
          end
        end
      end
      StHold: begin
        if (abort) begin
          w_state_nxt = StIdle;
          w_line_nxt  = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - HOLD_W'(1);
        end else if (r_idx < r_last) begin
          // Compare before incrementing so last = all-ones never wraps.
          w_idx_nxt  = w_step_idx;
          w_cnt_nxt  = r_reload;
          w_line_nxt = w_one << w_step_idx;
        end else begin
          w_state_nxt = StIdle;
          w_line_nxt  = '0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_line_nxt  = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_last   <= '0;
      r_cnt    <= '0;
      r_reload <= '0;
      r_line   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
      r_reload <= w_reload_nxt;
      r_line   <= w_line_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign out       = ACTIVE_LOW ? ~r_line : r_line;
  assign out_valid = (r_state == StHold);
  assign busy      = (r_state == StHold);
  assign in_ready  = (r_state == StIdle);
  assign done      = r_done;
  assign err       = r_err;

endmodule
